// File: rtl/bus_pkg.sv
// Shared definitions for the select-decoded system bus peripherals.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } bus_state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_SEL_W  = 2;

  // Select codes of the peripherals sharing the data bus
  localparam logic [DEF_SEL_W-1:0] RAM_SEL  = 2'b00;
  localparam logic [DEF_SEL_W-1:0] UART_SEL = 2'b01;
  localparam logic [DEF_SEL_W-1:0] GPIO_SEL = 2'b10;
  localparam logic [DEF_SEL_W-1:0] TMR_SEL  = 2'b11;

endpackage

// File: rtl/bus_ram_mem.sv
// DEPTH x DATA_W storage with synchronous write and registered read.
module bus_ram_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_ram_ctrl.sv
// Clocked bus RAM with req/ack handshake, registered read and wrapping bursts.
module bus_ram_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned          DATA_W = DEF_DATA_W,
  parameter int unsigned          ADDR_W = DEF_ADDR_W,
  parameter int unsigned          SEL_W  = DEF_SEL_W,
  parameter logic [SEL_W-1:0]     SEL_ID = '0
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [DATA_W-1:0]   io,
  input  logic                rd_wr,
  input  logic [SEL_W-1:0]    s,
  input  logic [ADDR_W-1:0]   address,
  input  logic                req,
  input  logic                burst,
  output logic                ack,
  output logic                en
);

  bus_state_t        state, state_next;
  logic              op;
  logic [ADDR_W-1:0] ptr, ptr_inc, acc_addr;
  logic              sel_hit, start, step, acc_we, acc_re;
  logic [DATA_W-1:0] rdata;

  assign sel_hit = (s == SEL_ID);
  assign ptr_inc = ADDR_W'(ptr + 1'b1);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    step       = 1'b0;
    acc_we     = 1'b0;
    acc_re     = 1'b0;
    acc_addr   = address;
    case (state)
      IDLE: begin
        if (req && sel_hit) begin
          state_next = XFER;
          start      = 1'b1;
          acc_we     = !rd_wr;
          acc_re     = rd_wr;
        end
      end
      XFER: begin
        if (req && burst && sel_hit) begin
          step     = 1'b1;
          acc_addr = ptr_inc;
          acc_we   = !op;
          acc_re   = op;
        end else if (req) begin
          state_next = HOLD;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (!req)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= 1'b0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        op  <= rd_wr;
        ptr <= address;
      end else if (step) begin
        ptr <= ptr_inc;
      end
    end
  end

  // The array has no reset, so writes must be suppressed while rst is high.
  bus_ram_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (acc_we && !rst),
    .waddr(acc_addr),
    .wdata(io),
    .re   (acc_re),
    .raddr(acc_addr),
    .rdata(rdata)
  );

  assign ack = (state == XFER);
  assign en  = (state == XFER) && op;
  assign io  = en ? rdata : 'z;

endmodule

// File: tb/tb_bus_ram_ctrl.sv
// Directed self-checking bench for bus_ram_ctrl.
module tb_bus_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] io;
  logic       rd_wr;
  logic [1:0] s;
  logic [4:0] address;
  logic       req;
  logic       burst;
  logic       ack;
  logic       en;
  logic       tb_oe;
  logic [7:0] tb_drv;

  int checks = 0;
  int errors = 0;

  assign io = tb_oe ? tb_drv : 'z;

  always #5 clk = ~clk;

  bus_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .SEL_W(2), .SEL_ID(2'b00)) dut (
    .clk(clk), .rst(rst), .io(io), .rd_wr(rd_wr), .s(s), .address(address),
    .req(req), .burst(burst), .ack(ack), .en(en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    req = 1'b0; burst = 1'b0; tb_oe = 1'b0; s = 2'b00; rd_wr = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    s = 2'b00; rd_wr = 1'b0; burst = 1'b0; address = a;
    tb_drv = d; tb_oe = 1'b1; req = 1'b1;
    tick();
    idle_bus();
    tick();
  endtask

  task automatic do_read(input logic [4:0] a, output logic [7:0] d, output logic a_seen);
    s = 2'b00; rd_wr = 1'b1; burst = 1'b0; address = a; tb_oe = 1'b0; req = 1'b1;
    tick();
    d = io; a_seen = ack && en;
    idle_bus();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_bus(); address = '0; tb_drv = '0;
    tick(); tick();
    checks++;
    if (ack !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL reset_outputs ack=%b en=%b expected 0 0", ack, en);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    s = 2'b00; rd_wr = 1'b0; burst = 1'b0; address = 5'd5;
    tb_drv = 8'hA5; tb_oe = 1'b1; req = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b1 || en !== 1'b0) begin
      errors++; $display("FAIL single_write_ack ack=%b en=%b expected 1 0", ack, en);
    end
    idle_bus();
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL single_write_end ack=%b expected 0", ack);
    end
    rd_wr = 1'b1; address = 5'd5; req = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b1 || en !== 1'b1 || io !== 8'hA5) begin
      errors++; $display("FAIL single_read ack=%b en=%b io=%h expected 1 1 a5", ack, en, io);
    end
    idle_bus();
    tick();
    checks++;
    if (ack !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL single_read_release ack=%b en=%b expected 0 0", ack, en);
    end
  endtask

  task automatic test_deselect();
    logic [7:0] d;
    logic       a_seen;
    s = 2'b01; rd_wr = 1'b0; burst = 1'b0; address = 5'd5;
    tb_drv = 8'hFF; tb_oe = 1'b1; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ack !== 1'b0 || en !== 1'b0) begin
        errors++; $display("FAIL deselect_cycle%0d ack=%b en=%b expected 0 0", i, ack, en);
      end
    end
    idle_bus();
    tick();
    do_read(5'd5, d, a_seen);
    checks++;
    if (d !== 8'hA5 || a_seen !== 1'b1) begin
      errors++; $display("FAIL deselect_readback data=%h ack_en=%b expected a5 1", d, a_seen);
    end
  endtask

  task automatic test_burst_write();
    logic [7:0] wdat [4];
    logic [4:0] raddr [4];
    logic [7:0] d;
    logic       a_seen;
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    raddr[0] = 5'd30; raddr[1] = 5'd31; raddr[2] = 5'd0; raddr[3] = 5'd1;
    s = 2'b00; rd_wr = 1'b0; burst = 1'b1; address = 5'd30;
    tb_drv = wdat[0]; tb_oe = 1'b1; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ack !== 1'b1 || en !== 1'b0) begin
        errors++; $display("FAIL burst_write_ack%0d ack=%b en=%b expected 1 0", i, ack, en);
      end
      if (i < 3) tb_drv = wdat[i+1];
      else idle_bus();
    end
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL burst_write_end ack=%b expected 0", ack);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(raddr[i], d, a_seen);
      checks++;
      if (d !== wdat[i] || a_seen !== 1'b1) begin
        errors++; $display("FAIL burst_write_mem%0d addr=%0d data=%h expected %h", i, raddr[i], d, wdat[i]);
      end
    end
  endtask

  task automatic test_burst_read();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    s = 2'b00; rd_wr = 1'b1; burst = 1'b1; address = 5'd30; tb_oe = 1'b0; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ack !== 1'b1 || en !== 1'b1 || io !== exp_d[i]) begin
        errors++; $display("FAIL burst_read%0d ack=%b en=%b io=%h expected 1 1 %h", i, ack, en, io, exp_d[i]);
      end
      if (i == 3) idle_bus();
    end
    tick();
    checks++;
    if (ack !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL burst_read_turnaround ack=%b en=%b expected 0 0", ack, en);
    end
  endtask

  task automatic test_held_req();
    int         acks = 0;
    logic [7:0] d;
    logic       a_seen;
    s = 2'b00; rd_wr = 1'b1; burst = 1'b0; address = 5'd5; tb_oe = 1'b0; req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL held_req_acks count=%0d expected 1", acks);
    end
    idle_bus();
    tick();
    checks++;
    if (ack !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL held_req_release ack=%b en=%b expected 0 0", ack, en);
    end
    do_read(5'd0, d, a_seen);
    checks++;
    if (d !== 8'h33 || a_seen !== 1'b1) begin
      errors++; $display("FAIL held_req_next data=%h ack_en=%b expected 33 1", d, a_seen);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] d;
    logic       a_seen;
    do_write(5'd11, 8'h77);
    s = 2'b00; rd_wr = 1'b0; burst = 1'b1; address = 5'd10;
    tb_drv = 8'h55; tb_oe = 1'b1; req = 1'b1;
    tick();
    tb_drv = 8'h66;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_write ack=%b en=%b expected 0 0", ack, en);
    end
    tick();
    idle_bus();
    #2 rst = 1'b0;
    tick();
    do_read(5'd10, d, a_seen);
    checks++;
    if (d !== 8'h55 || a_seen !== 1'b1) begin
      errors++; $display("FAIL rst_first_word data=%h ack_en=%b expected 55 1", d, a_seen);
    end
    do_read(5'd11, d, a_seen);
    checks++;
    if (d !== 8'h77) begin
      errors++; $display("FAIL rst_abandoned_word data=%h expected 77", d);
    end
    s = 2'b00; rd_wr = 1'b1; burst = 1'b1; address = 5'd30; req = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_read ack=%b en=%b expected 0 0", ack, en);
    end
    idle_bus();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_deselect();
    test_burst_write();
    test_burst_read();
    test_held_req();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
